// File: rtl/dla_soc2gb_apb_bridge.sv
// APB3 slave bridge into the SOC2GB register-interface strobe protocol.
// Optional read timeout is compiled in with `define SOC2GB_RD_TIMEOUT_EN.
module dla_soc2gb_apb_bridge #(
  parameter int          ADDR_W      = 22,
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic [ADDR_W-3:0] regif_soc2gb_addr,
  output logic              regif_soc2gb_wen,
  output logic              regif_soc2gb_ren,
  output logic [31:0]       regif_wdata,
  input  logic [31:0]       regif_soc2gb_rdata,
  input  logic              regif_soc2gb_rvalid
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RD_RESP} state_t;

  state_t            state_reg, state_next;
  logic              wen_reg, wen_next;
  logic              ren_reg, ren_next;
  logic              err_reg, err_next;
  logic [ADDR_W-3:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       prdata_reg, prdata_next;

`ifdef SOC2GB_RD_TIMEOUT_EN
  logic [7:0]        cnt_reg, cnt_next;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      wen_reg    <= 1'b0;
      ren_reg    <= 1'b0;
      err_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      prdata_reg <= '0;
`ifdef SOC2GB_RD_TIMEOUT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      wen_reg    <= wen_next;
      ren_reg    <= ren_next;
      err_reg    <= err_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      prdata_reg <= prdata_next;
`ifdef SOC2GB_RD_TIMEOUT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    wen_next    = 1'b0;
    ren_next    = 1'b0;
    err_next    = err_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    prdata_next = prdata_reg;
`ifdef SOC2GB_RD_TIMEOUT_EN
    cnt_next    = '0;
`endif
    case (state_reg)
      IDLE: begin
        if (psel && !penable) begin
          addr_next  = paddr[ADDR_W-1:2];
          wdata_next = pwdata;
          state_next = ACCESS;
          if (paddr[1:0] == 2'b00) begin
            wen_next = pwrite;
            ren_next = !pwrite;
            err_next = 1'b0;
          end else begin
            // Misaligned: no downstream access, error reported in access cycle
            err_next = 1'b1;
            if (!pwrite)
              prdata_next = ERR_RDATA;
          end
        end
      end
      ACCESS: begin
        // ren_reg is high only in the access cycle of an aligned read
        if (!psel || !ren_reg)
          state_next = IDLE;
        else
          state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (regif_soc2gb_rvalid) begin
          prdata_next = regif_soc2gb_rdata;
          err_next    = 1'b0;
          state_next  = RD_RESP;
        end
`ifdef SOC2GB_RD_TIMEOUT_EN
        else if (cnt_reg == 8'(TIMEOUT_CYC - 1)) begin
          prdata_next = ERR_RDATA;
          err_next    = 1'b1;
          state_next  = RD_RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
`endif
      end
      RD_RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    pready  = ((state_reg == ACCESS) && !ren_reg) || (state_reg == RD_RESP);
    pslverr = pready && err_reg;
  end

  assign prdata              = prdata_reg;
  assign regif_soc2gb_addr   = addr_reg;
  assign regif_soc2gb_wen    = wen_reg;
  assign regif_soc2gb_ren    = ren_reg;
  assign regif_wdata         = wdata_reg;

endmodule
